// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE TCDM datapath.
package redmule_pkg;

   localparam int unsigned DATA_W        = 256;
   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned TCDM_NARROW_W = 32;
   localparam int unsigned TCDM_BYTE_OFF = 2;

   // One narrow response as it is buffered per port: opcode flag above data.
   typedef struct packed {
      logic                     opc;
      logic [TCDM_NARROW_W-1:0] data;
   } tcdm_rsp_t;

   // Byte address of narrow word idx inside a wide beat; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] narrow_addr(input logic [ADDR_W-1:0] base,
                                                     input int unsigned       idx);
      return base + (ADDR_W'(idx) << TCDM_BYTE_OFF);
   endfunction

endpackage

// File: rtl/redmule_tcdm_rsp_fifo.sv
// Per-port first-word-fall-through response buffer. A push into an empty
// FIFO that is popped in the same cycle bypasses storage entirely, so the
// head output shows the incoming word whenever the FIFO is empty.
module redmule_tcdm_rsp_fifo
   import redmule_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      i_push,
   input  tcdm_rsp_t i_data,
   input  logic      i_pop,
   output tcdm_rsp_t o_data,
   output logic      o_empty
);

   localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CW = $clog2(Depth + 1);

   tcdm_rsp_t       r_mem [Depth];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_cnt;

   logic            w_full;
   logic            w_bypass;
   logic            w_store;
   logic            w_take;

   // Pointer advance with wrap at Depth (Depth need not be a power of two).
   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] ptr);
      if (ptr == PW'(Depth - 1)) begin
         return '0;
      end else begin
         return ptr + PW'(1);
      end
   endfunction

   // Decide whether the incoming word is stored, passed through, or a stored word leaves.
   always_comb begin
      o_empty  = (r_cnt == CW'(0));
      w_full   = (r_cnt == CW'(Depth));
      w_bypass = i_push & i_pop & o_empty;
      w_store  = i_push & ~w_bypass & (~w_full | i_pop);
      w_take   = i_pop & ~o_empty;
      if (o_empty) begin
         o_data = i_data;
      end else begin
         o_data = r_mem[r_rd_ptr];
      end
   end

   // Storage array, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < Depth; k++) begin
            r_mem[k] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_store) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= inc_ptr(r_wr_ptr);
         end
         if (w_take) begin
            r_rd_ptr <= inc_ptr(r_rd_ptr);
         end
         case ({w_store, w_take})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   redmule_tcdm_rsp_fifo_chk u_chk (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_push (i_push),
      .i_pop  (i_pop),
      .i_full (w_full)
   );

endmodule

// Protocol checks for the response FIFO: a response must never arrive
// while the port buffer is full and nothing is leaving.
module redmule_tcdm_rsp_fifo_chk (
   input logic clk_i,
   input logic rst_ni,
   input logic i_push,
   input logic i_pop,
   input logic i_full
);

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(i_push && i_full && !i_pop));

endmodule

// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide TCDM master stream into MP independent 32-bit ports.
// Narrow grants are collected in a mask until every port has accepted the
// beat; narrow responses are realigned in per-port FIFOs and released as one
// wide response once every port has one. A credit counter bounds the number
// of wide transactions in flight so the FIFOs can never overflow.
module redmule_tcdm_splitter
   import redmule_pkg::*;
#(
   parameter  int unsigned DW    = DATA_W,
   parameter  int unsigned Depth = 2,
   localparam int unsigned MP    = DW / TCDM_NARROW_W
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   // wide side
   input  logic                                wide_req_i,
   output logic                                wide_gnt_o,
   input  logic [ADDR_W-1:0]                   wide_add_i,
   input  logic                                wide_wen_i,
   input  logic [DW/8-1:0]                     wide_be_i,
   input  logic [DW-1:0]                       wide_data_i,
   output logic [DW-1:0]                       wide_r_data_o,
   output logic                                wide_r_valid_o,
   output logic                                wide_r_opc_o,
   // narrow request side
   output logic [MP-1:0]                       tcdm_req_o,
   input  logic [MP-1:0]                       tcdm_gnt_i,
   output logic [MP-1:0][ADDR_W-1:0]           tcdm_add_o,
   output logic [MP-1:0]                       tcdm_wen_o,
   output logic [MP-1:0][3:0]                  tcdm_be_o,
   output logic [MP-1:0][TCDM_NARROW_W-1:0]    tcdm_data_o,
   // narrow response side
   input  logic [MP-1:0][TCDM_NARROW_W-1:0]    tcdm_r_data_i,
   input  logic [MP-1:0]                       tcdm_r_valid_i,
   input  logic [MP-1:0]                       tcdm_r_opc_i
);

   localparam int unsigned       CW         = $clog2(Depth + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((DW / 8) - 1);

   logic [MP-1:0]   r_granted;
   logic [CW-1:0]   r_cnt;

   logic [ADDR_W-1:0] w_base;
   logic              w_active;
   logic [MP-1:0]     w_hit;
   logic [MP-1:0]     w_empty;
   logic [MP-1:0]     w_avail;
   tcdm_rsp_t         w_push_data [MP];
   tcdm_rsp_t         w_head      [MP];

   // Narrow payload: aligned address plus word offset, be/data slices, replicated wen.
   always_comb begin
      w_base = wide_add_i & ALIGN_MASK;
      for (int i = 0; i < MP; i++) begin
         tcdm_add_o[i]  = narrow_addr(w_base, i);
         tcdm_be_o[i]   = wide_be_i[4*i +: 4];
         tcdm_data_o[i] = wide_data_i[TCDM_NARROW_W*i +: TCDM_NARROW_W];
         tcdm_wen_o[i]  = wide_wen_i;
      end
   end

   // Request/grant path: a transaction starts only with credit, but once any
   // port has been granted it keeps requesting until every port has accepted.
   always_comb begin
      w_active   = (r_cnt < CW'(Depth)) | (|r_granted);
      tcdm_req_o = {MP{w_active & wide_req_i & rst_ni}} & ~r_granted;
      w_hit      = r_granted | (tcdm_req_o & tcdm_gnt_i);
      wide_gnt_o = &w_hit;
   end

   // Response path: a port is ready when it has a buffered word or one arriving now.
   always_comb begin
      w_avail        = ~w_empty | tcdm_r_valid_i;
      wide_r_valid_o = rst_ni & (&w_avail);
      wide_r_opc_o   = 1'b0;
      for (int i = 0; i < MP; i++) begin
         w_push_data[i].data = tcdm_r_data_i[i];
         w_push_data[i].opc  = tcdm_r_opc_i[i];
         wide_r_data_o[TCDM_NARROW_W*i +: TCDM_NARROW_W] = w_head[i].data;
         wide_r_opc_o = wide_r_opc_o | w_head[i].opc;
      end
   end

   for (genvar g = 0; g < MP; g++) begin : gen_rsp_fifo
      redmule_tcdm_rsp_fifo #(
         .Depth (Depth)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .i_push  (tcdm_r_valid_i[g]),
         .i_data  (w_push_data[g]),
         .i_pop   (wide_r_valid_o),
         .o_data  (w_head[g]),
         .o_empty (w_empty[g])
      );
   end

   // Grant mask: remember partial grants, clear once the whole beat is accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_granted <= '0;
      end else if (wide_gnt_o) begin
         r_granted <= '0;
      end else begin
         r_granted <= w_hit;
      end
   end

   // Outstanding wide transactions; a response frees credit only from the next cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else begin
         case ({wide_gnt_o, wide_r_valid_o})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter with DW=128 (4 narrow ports), Depth=2.
// Expected wide responses are queued when the narrow responses are driven and
// compared by a monitor whenever the DUT presents wide_r_valid_o.
module tb_redmule_tcdm_splitter;

   localparam int unsigned DW = 128;
   localparam int unsigned MP = 4;
   localparam int unsigned DP = 2;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 wide_req_i;
   logic                 wide_gnt_o;
   logic [31:0]          wide_add_i;
   logic                 wide_wen_i;
   logic [DW/8-1:0]      wide_be_i;
   logic [DW-1:0]        wide_data_i;
   logic [DW-1:0]        wide_r_data_o;
   logic                 wide_r_valid_o;
   logic                 wide_r_opc_o;
   logic [MP-1:0]        tcdm_req_o;
   logic [MP-1:0]        tcdm_gnt_i;
   logic [MP-1:0][31:0]  tcdm_add_o;
   logic [MP-1:0]        tcdm_wen_o;
   logic [MP-1:0][3:0]   tcdm_be_o;
   logic [MP-1:0][31:0]  tcdm_data_o;
   logic [MP-1:0][31:0]  tcdm_r_data_i;
   logic [MP-1:0]        tcdm_r_valid_i;
   logic [MP-1:0]        tcdm_r_opc_i;

   typedef struct {
      logic [DW-1:0] data;
      logic          opc;
   } exp_t;

   exp_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   redmule_tcdm_splitter #(.DW(DW), .Depth(DP)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .wide_req_i     (wide_req_i),
      .wide_gnt_o     (wide_gnt_o),
      .wide_add_i     (wide_add_i),
      .wide_wen_i     (wide_wen_i),
      .wide_be_i      (wide_be_i),
      .wide_data_i    (wide_data_i),
      .wide_r_data_o  (wide_r_data_o),
      .wide_r_valid_o (wide_r_valid_o),
      .wide_r_opc_o   (wide_r_opc_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .tcdm_r_opc_i   (tcdm_r_opc_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic idle();
      wide_req_i     = 1'b0;
      tcdm_gnt_i     = 4'h0;
      tcdm_r_valid_i = 4'h0;
      tcdm_r_opc_i   = 4'h0;
   endtask

   task automatic respond(input logic [3:0] mask, input logic [31:0] base, input logic [3:0] opc);
      for (int i = 0; i < MP; i++) begin
         tcdm_r_data_i[i] = base + 32'(i);
      end
      tcdm_r_valid_i = mask;
      tcdm_r_opc_i   = opc;
   endtask

   task automatic exp_rsp(input logic [31:0] base, input logic opc);
      exp_t e;
      e.data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
      e.opc  = opc;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every wide response must match the oldest expected one.
   always @(negedge clk_i) begin
      if (rst_ni && wide_r_valid_o) begin
         n_tests++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL rsp_unexpected: observed valid response, expected none (data %h)", wide_r_data_o);
         end
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_data", wide_r_data_o, e.data);
            chk("rsp_opc", DW'(wide_r_opc_o), DW'(e.opc));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: request and narrow inputs active, outputs must stay quiet.
      rst_ni         = 1'b0;
      wide_req_i     = 1'b1;
      wide_add_i     = 32'h0;
      wide_wen_i     = 1'b1;
      wide_be_i      = '1;
      wide_data_i    = '0;
      tcdm_gnt_i     = 4'hF;
      tcdm_r_valid_i = 4'hF;
      tcdm_r_opc_i   = 4'h0;
      tcdm_r_data_i  = '0;
      #3;
      chk("rst_req", DW'(tcdm_req_o), DW'(4'h0));
      chk("rst_gnt", DW'(wide_gnt_o), DW'(1'b0));
      chk("rst_rvalid", DW'(wide_r_valid_o), DW'(1'b0));
      step();
      rst_ni = 1'b1;
      idle();
      step();

      // T1: read, all grants same cycle, all responses next cycle.
      wide_req_i = 1'b1; wide_add_i = 32'h0000_1000; wide_wen_i = 1'b1; tcdm_gnt_i = 4'hF;
      #1;
      chk("t1_req", DW'(tcdm_req_o), DW'(4'hF));
      chk("t1_gnt", DW'(wide_gnt_o), DW'(1'b1));
      chk("t1_add0", DW'(tcdm_add_o[0]), DW'(32'h0000_1000));
      chk("t1_add1", DW'(tcdm_add_o[1]), DW'(32'h0000_1004));
      chk("t1_add2", DW'(tcdm_add_o[2]), DW'(32'h0000_1008));
      chk("t1_add3", DW'(tcdm_add_o[3]), DW'(32'h0000_100C));
      chk("t1_wen", DW'(tcdm_wen_o), DW'(4'hF));
      step();
      idle();
      respond(4'hF, 32'hA0, 4'h0); exp_rsp(32'hA0, 1'b0);
      #1;
      chk("t1_rvalid", DW'(wide_r_valid_o), DW'(1'b1));
      chk("t1_rdata", wide_r_data_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      step();
      idle();
      #1;
      chk("t1_rvalid_off", DW'(wide_r_valid_o), DW'(1'b0));

      // T2: write with staggered grants, port 2 last; unaligned low bits ignored.
      step();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_2005; wide_wen_i = 1'b0;
      wide_be_i = 16'h8421;
      wide_data_i = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
      tcdm_gnt_i = 4'b1011;
      #1;
      chk("t2_req_c0", DW'(tcdm_req_o), DW'(4'hF));
      chk("t2_gnt_c0", DW'(wide_gnt_o), DW'(1'b0));
      chk("t2_add0", DW'(tcdm_add_o[0]), DW'(32'h0000_2000));
      chk("t2_be2", DW'(tcdm_be_o[2]), DW'(4'h4));
      chk("t2_data3", DW'(tcdm_data_o[3]), DW'(32'hD3D3_D3D3));
      chk("t2_wen", DW'(tcdm_wen_o), DW'(4'h0));
      for (int c = 1; c < 3; c++) begin
         step();
         tcdm_gnt_i = 4'h0;
         #1;
         chk("t2_req_mid", DW'(tcdm_req_o), DW'(4'b0100));
         chk("t2_gnt_mid", DW'(wide_gnt_o), DW'(1'b0));
      end
      step();
      tcdm_gnt_i = 4'b0100;
      #1;
      chk("t2_req_c3", DW'(tcdm_req_o), DW'(4'b0100));
      chk("t2_gnt_c3", DW'(wide_gnt_o), DW'(1'b1));
      step();
      idle();
      #1;
      chk("t2_req_after", DW'(tcdm_req_o), DW'(4'h0));
      chk("t2_gnt_after", DW'(wide_gnt_o), DW'(1'b0));

      // T3: skewed responses for the T2 write: ports 0,1 early, ports 2,3 later.
      step();
      respond(4'b0011, 32'hB0, 4'h0);
      #1;
      chk("t3_rvalid_early", DW'(wide_r_valid_o), DW'(1'b0));
      for (int c = 0; c < 3; c++) begin
         step();
         idle();
         #1;
         chk("t3_rvalid_wait", DW'(wide_r_valid_o), DW'(1'b0));
      end
      step();
      respond(4'b1100, 32'hB0, 4'h0); exp_rsp(32'hB0, 1'b0);
      #1;
      chk("t3_rvalid", DW'(wide_r_valid_o), DW'(1'b1));
      step();
      idle();
      #1;
      chk("t3_rvalid_off", DW'(wide_r_valid_o), DW'(1'b0));

      // T4: credit limit, third write blocked until a response frees credit.
      step();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_4000; wide_wen_i = 1'b0; tcdm_gnt_i = 4'hF;
      #1;
      chk("t4_gnt_a", DW'(wide_gnt_o), DW'(1'b1));
      step();
      wide_add_i = 32'h0000_4010;
      #1;
      chk("t4_gnt_b", DW'(wide_gnt_o), DW'(1'b1));
      step();
      wide_add_i = 32'h0000_4020;
      #1;
      chk("t4_req_blocked", DW'(tcdm_req_o), DW'(4'h0));
      chk("t4_gnt_blocked", DW'(wide_gnt_o), DW'(1'b0));
      step();
      respond(4'hF, 32'hC0, 4'h0); exp_rsp(32'hC0, 1'b0);
      #1;
      chk("t4_rvalid_a", DW'(wide_r_valid_o), DW'(1'b1));
      chk("t4_req_same_cycle", DW'(tcdm_req_o), DW'(4'h0));
      step();
      tcdm_r_valid_i = 4'h0;
      #1;
      chk("t4_req_freed", DW'(tcdm_req_o), DW'(4'hF));
      chk("t4_gnt_c", DW'(wide_gnt_o), DW'(1'b1));
      step();
      idle();
      respond(4'hF, 32'hE0, 4'h0); exp_rsp(32'hE0, 1'b0);
      #1;
      chk("t4_rvalid_b", DW'(wide_r_valid_o), DW'(1'b1));
      step();
      respond(4'hF, 32'hF0, 4'h0); exp_rsp(32'hF0, 1'b0);
      #1;
      chk("t4_rvalid_c", DW'(wide_r_valid_o), DW'(1'b1));
      step();
      idle();

      // T5: address wrap and opc reduction.
      step();
      wide_req_i = 1'b1; wide_add_i = 32'hFFFF_FFF0; wide_wen_i = 1'b1; tcdm_gnt_i = 4'hF;
      #1;
      chk("t5_add0", DW'(tcdm_add_o[0]), DW'(32'hFFFF_FFF0));
      chk("t5_add1", DW'(tcdm_add_o[1]), DW'(32'hFFFF_FFF4));
      chk("t5_add2", DW'(tcdm_add_o[2]), DW'(32'hFFFF_FFF8));
      chk("t5_add3", DW'(tcdm_add_o[3]), DW'(32'hFFFF_FFFC));
      chk("t5_gnt", DW'(wide_gnt_o), DW'(1'b1));
      step();
      idle();
      respond(4'hF, 32'h50, 4'b0100); exp_rsp(32'h50, 1'b1);
      #1;
      chk("t5_opc", DW'(wide_r_opc_o), DW'(1'b1));
      step();
      idle();

      // T6: reset in the middle of a partially granted transaction.
      step();
      wide_req_i = 1'b1; wide_add_i = 32'h0000_3000; wide_wen_i = 1'b1; tcdm_gnt_i = 4'b0011;
      #1;
      chk("t6_req_c0", DW'(tcdm_req_o), DW'(4'hF));
      chk("t6_gnt_c0", DW'(wide_gnt_o), DW'(1'b0));
      step();
      tcdm_gnt_i = 4'h0;
      #1;
      chk("t6_req_c1", DW'(tcdm_req_o), DW'(4'b1100));
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_req", DW'(tcdm_req_o), DW'(4'h0));
      chk("t6_rst_gnt", DW'(wide_gnt_o), DW'(1'b0));
      chk("t6_rst_rvalid", DW'(wide_r_valid_o), DW'(1'b0));
      step();
      rst_ni = 1'b1;
      tcdm_gnt_i = 4'b0011;
      #1;
      chk("t6_fresh_req", DW'(tcdm_req_o), DW'(4'hF));
      chk("t6_fresh_gnt", DW'(wide_gnt_o), DW'(1'b0));
      step();
      tcdm_gnt_i = 4'b1100;
      #1;
      chk("t6_fresh_req2", DW'(tcdm_req_o), DW'(4'b1100));
      chk("t6_fresh_gnt2", DW'(wide_gnt_o), DW'(1'b1));
      step();
      idle();
      respond(4'hF, 32'h60, 4'h0); exp_rsp(32'h60, 1'b0);
      #1;
      chk("t6_rvalid", DW'(wide_r_valid_o), DW'(1'b1));
      step();
      idle();
      #1;
      chk("t6_rvalid_off", DW'(wide_r_valid_o), DW'(1'b0));

      step();
      chk("queue_drained", DW'(exp_q.size()), DW'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
